// File: rtl/thermal_guard.sv
// Multi-channel overheat shutdown controller: per-channel debounced trip, timed
// hysteretic release, and trip-count lockout cleared by a shared pulse.
module thermal_guard #(
  parameter int unsigned N         = 4,
  parameter int unsigned W         = 8,
  parameter int unsigned HOT       = 100,
  parameter int unsigned COOL      = 80,
  parameter int unsigned DEBOUNCE  = 3,
  parameter int unsigned HOLD      = 16,
  parameter int unsigned MAX_TRIPS = 3,
  localparam int unsigned C        = $clog2(MAX_TRIPS + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N*W-1:0] temp,
  input  logic           lockout_clr,
  output logic [N-1:0]   shut_off_computer,
  output logic [N-1:0]   locked,
  output logic           any_shut_off,
  output logic [N*C-1:0] trip_count
);

  localparam int unsigned DW = $clog2(DEBOUNCE + 1);
  localparam int unsigned HW = $clog2(HOLD + 1);

  typedef enum logic [1:0] {StRun, StShut, StCoolDn, StLock} state_e;

  logic [N-1:0] shut_d_vec;
  logic         any_q;

  for (genvar i = 0; i < N; i++) begin : g_ch
    state_e        state_q, state_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [C-1:0]  trips_q, trips_d, trips_base;
    logic          shut_q, lock_q;
    logic          hot, cool;

    assign hot  = 32'(temp[i*W +: W]) >= HOT;
    assign cool = 32'(temp[i*W +: W]) <= COOL;
    // A clear in the same cycle takes effect before any increment or lock decision.
    assign trips_base = lockout_clr ? '0 : trips_q;

    always_comb begin
      state_d = state_q;
      deb_d   = deb_q;
      hold_d  = hold_q;
      trips_d = trips_base;
      unique case (state_q)
        StRun: begin
          if (!hot) begin
            deb_d = '0;
          end else if (32'(deb_q) + 32'd1 >= DEBOUNCE) begin
            state_d = StShut;
            deb_d   = '0;
            if (32'(trips_base) < MAX_TRIPS) trips_d = trips_base + C'(1);
          end else begin
            deb_d = deb_q + DW'(1);
          end
        end
        StShut: begin
          if (cool) begin
            state_d = StCoolDn;
            hold_d  = HW'(HOLD);
          end
        end
        StCoolDn: begin
          if (!cool) begin
            state_d = StShut;
          end else if (hold_q == HW'(1)) begin
            state_d = (32'(trips_base) == MAX_TRIPS) ? StLock : StRun;
            deb_d   = '0;
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
        StLock: begin
          if (lockout_clr) state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end

    assign shut_d_vec[i] = (state_d != StRun);

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= StRun;
        deb_q   <= '0;
        hold_q  <= '0;
        trips_q <= '0;
        shut_q  <= 1'b0;
        lock_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        deb_q   <= deb_d;
        hold_q  <= hold_d;
        trips_q <= trips_d;
        shut_q  <= shut_d_vec[i];
        lock_q  <= (state_d == StLock);
      end
    end

    assign shut_off_computer[i]  = shut_q;
    assign locked[i]             = lock_q;
    assign trip_count[i*C +: C]  = trips_q;
  end

  always_ff @(posedge clk) begin
    if (reset) any_q <= 1'b0;
    else       any_q <= |shut_d_vec;
  end

  assign any_shut_off = any_q;

endmodule

// File: tb/tb_thermal_guard.sv
// Bench for thermal_guard: directed scenarios with literal expectations plus
// randomized regimes checked every cycle against a streak-counting model.
module tb_thermal_guard;
  localparam int N = 4, W = 8, HOT = 100, COOL = 80, DEBOUNCE = 3, HOLD = 16, MAX_TRIPS = 3;
  localparam int C = $clog2(MAX_TRIPS + 1);

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N*W-1:0] temp = '0;
  logic           lockout_clr = 1'b0;
  logic [N-1:0]   shut_off_computer, locked;
  logic           any_shut_off;
  logic [N*C-1:0] trip_count;

  thermal_guard #(
    .N(N), .W(W), .HOT(HOT), .COOL(COOL), .DEBOUNCE(DEBOUNCE), .HOLD(HOLD),
    .MAX_TRIPS(MAX_TRIPS)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .temp              (temp),
    .lockout_clr       (lockout_clr),
    .shut_off_computer (shut_off_computer),
    .locked            (locked),
    .any_shut_off      (any_shut_off),
    .trip_count        (trip_count)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_pass = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a trip is DEBOUNCE consecutive hot samples while released; a release
  // is HOLD+1 consecutive cool samples while shut; locking happens at release time.
  int m_shut[N], m_lock[N], m_hot[N], m_cool[N], m_trips[N];
  int mt, te;

  initial begin
    for (int i = 0; i < N; i++) begin
      m_shut[i] = 0; m_lock[i] = 0; m_hot[i] = 0; m_cool[i] = 0; m_trips[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      mt = int'(temp[i*W +: W]);
      te = lockout_clr ? 0 : m_trips[i];
      if (reset) begin
        m_shut[i] = 0; m_lock[i] = 0; m_hot[i] = 0; m_cool[i] = 0; te = 0;
      end else if (m_lock[i] != 0) begin
        if (lockout_clr) begin
          m_lock[i] = 0;
          m_shut[i] = 0;
        end
      end else if (m_shut[i] == 0) begin
        if (mt >= HOT) begin
          m_hot[i]++;
          if (m_hot[i] == DEBOUNCE) begin
            m_shut[i] = 1; m_hot[i] = 0; m_cool[i] = 0;
            if (te < MAX_TRIPS) te++;
          end
        end else m_hot[i] = 0;
      end else begin
        if (mt <= COOL) begin
          m_cool[i]++;
          if (m_cool[i] == HOLD + 1) begin
            m_cool[i] = 0; m_hot[i] = 0;
            if (te == MAX_TRIPS) m_lock[i] = 1;
            else m_shut[i] = 0;
          end
        end else m_cool[i] = 0;
      end
      m_trips[i] = te;
    end
  end

  logic [N-1:0]   e_shut, e_lock;
  logic [N*C-1:0] e_trips;

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < N; i++) begin
        e_shut[i]          = (m_shut[i] != 0);
        e_lock[i]          = (m_lock[i] != 0);
        e_trips[i*C +: C]  = C'(m_trips[i]);
      end
      chk("model_shut", shut_off_computer, e_shut);
      chk("model_locked", locked, e_lock);
      chk("model_any", any_shut_off, |e_shut);
      chk("model_trips", trip_count, e_trips);
    end
  end

  task automatic drive(input int ch, input int val, input bit clr, input bit rst);
    temp = '0;
    temp[ch*W +: W] = W'(val);
    lockout_clr = clr;
    reset = rst;
    @(posedge clk);
    #1;
    lockout_clr = 1'b0;
    reset = 1'b0;
  endtask

  task automatic run_ch(input int ch, input int val, input int n);
    for (int k = 0; k < n; k++) drive(ch, val, 1'b0, 1'b0);
  endtask

  int regime[N], left[N];

  initial begin
    drive(0, 0, 1'b0, 1'b1);
    started = 1'b1;
    drive(0, 0, 1'b0, 1'b1);
    chk("reset_shut", shut_off_computer, 4'b0000);
    chk("reset_locked", locked, 4'b0000);
    chk("reset_any", any_shut_off, 1'b0);
    chk("reset_trips", trip_count, 8'h00);

    // Debounce
    run_ch(0, 100, 2); drive(0, 99, 1'b0, 1'b0); run_ch(0, 100, 2);
    chk("t1_not_yet", shut_off_computer, 4'b0000);
    run_ch(0, 100, 1);
    chk("t1_shut", shut_off_computer, 4'b0001);
    chk("t1_any", any_shut_off, 1'b1);
    chk("t1_trips", trip_count[1:0], 1);
    drive(0, 0, 1'b0, 1'b1);

    // Hysteresis band then release
    run_ch(1, 120, 3); run_ch(1, 90, 10); run_ch(1, 80, 16);
    chk("t2_hold", shut_off_computer, 4'b0010);
    run_ch(1, 80, 1);
    chk("t2_release", shut_off_computer, 4'b0000);

    // Cool-down interrupted at timer 5
    run_ch(2, 120, 3); run_ch(2, 80, 12); run_ch(2, 81, 1); run_ch(2, 80, 16);
    chk("t3_hold", shut_off_computer, 4'b0100);
    run_ch(2, 80, 1);
    chk("t3_release", shut_off_computer, 4'b0000);
    drive(0, 0, 1'b0, 1'b1);

    // Lockout after three trips
    for (int k = 1; k <= 3; k++) begin
      run_ch(3, 120, 3);
      chk("t4_trip", trip_count[7:6], k);
      run_ch(3, 0, 17);
    end
    chk("t4_locked", locked, 4'b1000);
    chk("t4_lock_shut", shut_off_computer, 4'b1000);
    run_ch(3, 0, 20);
    chk("t4_still_locked", locked, 4'b1000);
    drive(3, 0, 1'b1, 1'b0);
    chk("t4_clr_locked", locked, 4'b0000);
    chk("t4_clr_shut", shut_off_computer, 4'b0000);
    chk("t4_clr_trips", trip_count, 8'h00);

    // Reset mid-operation
    for (int k = 0; k < 3; k++) begin run_ch(3, 120, 3); run_ch(3, 0, 17); end
    run_ch(0, 120, 3);
    chk("t5_pre", {locked, shut_off_computer}, 8'h89);
    drive(0, 120, 1'b0, 1'b1);
    chk("t5_rst_shut", shut_off_computer, 4'b0000);
    chk("t5_rst_locked", locked, 4'b0000);
    chk("t5_rst_trips", trip_count, 8'h00);
    run_ch(0, 120, 2);
    chk("t5_not_yet", shut_off_computer, 4'b0000);
    run_ch(0, 120, 1);
    chk("t5_retrip", shut_off_computer, 4'b0001);
    drive(0, 0, 1'b0, 1'b1);

    // Clear coinciding with the tripping sample
    for (int k = 0; k < 2; k++) begin run_ch(1, 120, 3); run_ch(1, 0, 17); end
    chk("t6_pre_trips", trip_count[3:2], 2);
    run_ch(1, 120, 2);
    drive(1, 120, 1'b1, 1'b0);
    chk("t6_shut", shut_off_computer, 4'b0010);
    chk("t6_trips", trip_count[3:2], 1);
    run_ch(1, 0, 17);
    chk("t6_release", {locked, shut_off_computer}, 8'h00);

    // Randomized regimes per channel
    for (int i = 0; i < N; i++) left[i] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (left[i] == 0) begin
          regime[i] = $urandom_range(0, 3);
          left[i]   = $urandom_range(1, 50);
        end
        left[i]--;
        case (regime[i])
          0:       temp[i*W +: W] = W'($urandom_range(100, 255));
          1:       temp[i*W +: W] = W'($urandom_range(0, 80));
          2:       temp[i*W +: W] = W'($urandom_range(81, 99));
          default: temp[i*W +: W] = W'($urandom_range(78, 102));
        endcase
      end
      lockout_clr = ($urandom_range(0, 63) == 0);
      reset       = ($urandom_range(0, 999) == 0);
      @(posedge clk);
      #1;
    end
    lockout_clr = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/thermal_guard.md
# thermal_guard

Multi-channel overheat shutdown controller: the registered, debounced, hysteretic successor to the single-bit combinational overheat shut-off. Each of `N` channels compares a `W`-bit temperature sample against hot and cool thresholds. Each channel asserts its own shut-off after a debounced overheat and releases it only after a timed cool-down. After `MAX_TRIPS` trips the channel latches into lockout until software clears it.

## Interface
- `N`, 4, number of independent channels
- `W`, 8, temperature sample width (unsigned)
- `HOT`, 100, trip threshold; a sample is hot when `temp >= HOT`
- `COOL`, 80, release threshold; a sample is cool when `temp <= COOL`; must be `< HOT`
- `DEBOUNCE`, 3, consecutive hot samples needed to trip; `>= 1`
- `HOLD`, 16, consecutive cool cycles before release; `>= 1`
- `MAX_TRIPS`, 3, trips before lockout; `>= 1`

Ports (one clock; reset is synchronous, active-high):
- `clk` input 1: sole clock, rising edge
- `reset` input 1: synchronous active-high reset
- `temp` input N*W: channel i sample on bits `[i*W +: W]`, sampled every cycle
- `lockout_clr` input 1: single-cycle pulse; clears trip counters and lockouts on all channels
- `shut_off_computer` output N: per-channel shut-off, registered
- `locked` output N: per-channel lockout flag, registered
- `any_shut_off` output 1: OR of `shut_off_computer`, registered
- `trip_count` output N*C: per-channel trip count, where `C = $clog2(MAX_TRIPS+1)`, saturating at `MAX_TRIPS`

## Operation
Each channel runs an independent FSM with the states RUN, SHUT, COOLDN and LOCK, plus a debounce counter, a hold timer and a trip counter.

- **RUN** (`shut_off=0`)
  - A hot sample increments the debounce counter; any non-hot sample clears it to 0.
  - When the hot sample that makes the count equal `DEBOUNCE` is sampled, the channel goes to SHUT and the trip counter increments (saturating).
- **SHUT** (`shut_off=1`)
  - Holds while `temp > COOL`.
  - A cool sample moves the channel to COOLDN with the hold timer loaded to `HOLD`.
- **COOLDN** (`shut_off=1`)
  - Each cool sample decrements the timer.
  - A non-cool sample returns the channel to SHUT; the timer restarts on the next entry to COOLDN.
  - A cool sample with the timer at 1 leaves COOLDN:
    - to LOCK if `trip_count == MAX_TRIPS`;
    - otherwise to RUN, with the debounce counter at 0.
- **LOCK** (`shut_off=1`, `locked=1`)
  - Ignores `temp`.
  - `lockout_clr` moves the channel to RUN.

`lockout_clr` rules:
- In any state it zeroes `trip_count` on every channel.
- Outside LOCK it does not change the state.
- If `lockout_clr` coincides with the hot sample that trips a channel, the trip is taken and the trip counter ends at 1 (clear first, then increment).

Aggregate output: `any_shut_off` is registered from next-state values, so it is cycle-aligned with `shut_off_computer`.

Reset values: every channel in RUN, all counters 0, `shut_off_computer=0`, `locked=0`, `any_shut_off=0`, `trip_count=0`. Reset mid-shutdown or mid-lockout releases the channel on the next cycle.

## Timing
- All outputs are registered; nothing is combinational from input to output.
- Trip latency:
  - If the first of `DEBOUNCE` consecutive hot samples arrives in cycle t, `shut_off` is high from cycle t+DEBOUNCE.
  - With `DEBOUNCE=1`, the assertion follows the first hot sample by one cycle.
- Release latency:
  - If the first cool sample in SHUT arrives in cycle c and every sample through c+HOLD is cool, `shut_off` is high through cycle c+HOLD and low from cycle c+HOLD+1.
  - A non-cool sample in COOLDN extends the shutdown; the full `HOLD` count is needed after the next cool sample.
- Lockout:
  - `locked` rises in the same cycle the channel would otherwise have released.
  - If `lockout_clr` is sampled in cycle k, both `locked` and `shut_off` are low from k+1.
- Hysteresis band: samples with `COOL < temp < HOT` reset the debounce counter in RUN and keep the channel in SHUT, or return it there from COOLDN.
- Channels never interact, except through the shared `lockout_clr`.

## Test plan
Defaults apply throughout (`N=4`, `HOT=100`, `COOL=80`, `DEBOUNCE=3`, `HOLD=16`, `MAX_TRIPS=3`).

1. **Debounce:** ch0 `temp` = 100,100,99,100,100,100 from cycle 0 -> `shut_off[0]` rises only at cycle 6; `trip_count[0]=1`; `any_shut_off=1` at cycle 6; the other channels stay 0.
2. **Hysteresis/release:** ch1 tripped, then `temp=90` for 10 cycles, then 80 from cycle c -> `shut_off[1]` stays high through c+16 and is low at c+17.
3. **Cool-down interrupt:** ch2 in COOLDN; `temp=81` for one cycle at timer 5, then 80 again from cycle d -> release at d+17 (full `HOLD` restarts).
4. **Lockout:** three full trip/release cycles on ch3 -> after the third cool-down `locked[3]=1` and `shut_off[3]=1`, and `temp=0` does not release it. A `lockout_clr` pulse at cycle k -> `locked[3]=0`, `shut_off[3]=0`, `trip_count[3]=0` at k+1.
5. **Reset mid-operation:** ch0 in SHUT and ch3 in LOCK, `reset` high for one cycle -> next cycle all outputs 0. With `temp=120` held on ch0, it re-trips exactly 3 cycles after `reset` deasserts.
6. **Simultaneous events:** `lockout_clr` in the same cycle as ch1's third hot sample (`trip_count[1]=2` beforehand) -> ch1 trips and `trip_count[1]=1`, not lockout-eligible.
